// File: rtl/fc_param_loader.sv
// Host byte-stream loader for the fully-connected network's input vector and weight array.
// Optional trailer checksum state enabled by defining FC_LOADER_CHKSUM_EN.
module fc_param_loader #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 40,
  parameter int IDXW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  input  logic [7:0]      s_data,
  output logic            s_ready,
  output logic [IDXW-1:0] index1,
  output logic [IDXW-1:0] index2,
  output logic            din_we,
  output logic [7:0]      din,
  output logic            w_we,
  output logic [11:0]     wout,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [7:0] CMD_IN = 8'hA1;
  localparam logic [7:0] CMD_W  = 8'hA2;

`ifdef FC_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {IDLE, IN_LOAD, W_HI, W_LO, CHK, FIN} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {IDLE, IN_LOAD, W_HI, W_LO, FIN} state_t;
`endif

  state_t          state;
  logic [IDXW-1:0] ptr1, ptr2;  // address the next payload write will use
  logic [3:0]      w_hi;
  logic            fin_pend;
  logic            accept;
  logic            last_addr;

  assign accept = s_valid && s_ready;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    last_addr = 1'b0;
    if (ptr1 == IDXW'(N_IN - 1))
      last_addr = (state == IN_LOAD) ? (ptr2 == '0) : (ptr2 == IDXW'(N_OUT - 1));
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // right-hand side sees the pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      s_ready  <= 1'b1;
      index1   <= '0;
      index2   <= '0;
      ptr1     <= '0;
      ptr2     <= '0;
      din_we   <= 1'b0;
      din      <= '0;
      w_we     <= 1'b0;
      wout     <= '0;
      w_hi     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      fin_pend <= 1'b0;
`ifdef FC_LOADER_CHKSUM_EN
      csum     <= '0;
`endif
    end else begin
      din_we <= 1'b0;
      w_we   <= 1'b0;
      done   <= 1'b0;
      // Index outputs trail the pointer by one edge: they show the write address
      // during the strobe cycle and step forward on the following edge.
      index1 <= ptr1;
      index2 <= ptr2;

      if (fin_pend) begin
        // Final strobe cycle; a byte offered here lies beyond the load length and is dropped.
        fin_pend <= 1'b0;
        state    <= FIN;
        done     <= 1'b1;
        s_ready  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            if (s_data == CMD_IN || s_data == CMD_W) begin
              state  <= (s_data == CMD_IN) ? IN_LOAD : W_HI;
              err    <= 1'b0;
              busy   <= 1'b1;
              ptr1   <= '0;
              ptr2   <= '0;
              index1 <= '0;
              index2 <= '0;
`ifdef FC_LOADER_CHKSUM_EN
              csum   <= '0;
`endif
            end else begin
              err <= 1'b1;
            end
          end

          IN_LOAD, W_LO: if (accept) begin
            if (state == IN_LOAD) begin
              din    <= s_data;
              din_we <= 1'b1;
            end else begin
              wout  <= {w_hi, s_data};
              w_we  <= 1'b1;
              state <= W_HI;
            end
`ifdef FC_LOADER_CHKSUM_EN
            csum <= csum ^ s_data;
`endif
            if (last_addr) begin
              ptr1 <= '0;
              ptr2 <= '0;
`ifdef FC_LOADER_CHKSUM_EN
              state <= CHK;
`else
              state    <= state;
              fin_pend <= 1'b1;
`endif
            end else if (ptr1 == IDXW'(N_IN - 1)) begin
              ptr1 <= '0;
              ptr2 <= ptr2 + IDXW'(1);
            end else begin
              ptr1 <= ptr1 + IDXW'(1);
            end
          end

          W_HI: if (accept) begin
            w_hi  <= s_data[3:0];
            state <= W_LO;
`ifdef FC_LOADER_CHKSUM_EN
            csum  <= csum ^ s_data;
`endif
          end

`ifdef FC_LOADER_CHKSUM_EN
          CHK: if (accept) begin
            if (s_data == csum) begin
              state   <= FIN;
              done    <= 1'b1;
              s_ready <= 1'b0;
            end else begin
              state <= IDLE;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
`endif

          FIN: begin
            state   <= IDLE;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fc_param_loader.sv
// Directed bench for fc_param_loader: host-side scoreboard of expected writes,
// popped and compared whenever the loader issues a write strobe.
module tb_fc_param_loader;

  localparam int N_IN  = 784;
  localparam int N_OUT = 40;
  localparam int IDXW  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            s_valid = 1'b0;
  logic [7:0]      s_data = '0;
  logic            s_ready;
  logic [IDXW-1:0] index1, index2;
  logic            din_we, w_we, busy, done, err;
  logic [7:0]      din;
  logic [11:0]     wout;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int din_cnt = 0, w_cnt = 0, done_cnt = 0, srdy_low = 0;
  int last_strobe_cyc = -10;
  logic [63:0] sb[$];

  fc_param_loader #(.N_IN(N_IN), .N_OUT(N_OUT), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .index1(index1), .index2(index2), .din_we(din_we), .din(din), .w_we(w_we),
    .wout(wout), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input bit is_w, input int i1, input int i2, input int d);
    return {19'd0, is_w, i1[15:0], i2[15:0], d[11:0]};
  endfunction

  // Monitor: compare every write strobe against the scoreboard, and check done framing.
  always @(negedge clk) begin
    if (rst) begin
      if (!s_ready) srdy_low++;
      if (din_we || w_we) begin
        if (sb.size() == 0) check("strobe_unexpected", {62'd0, din_we, w_we}, 64'd0);
        else check("strobe", pack(w_we, index1, index2, w_we ? int'(wout) : int'(din)), sb.pop_front());
        if (din_we) din_cnt++;
        if (w_we) w_cnt++;
        last_strobe_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_frame", {busy, s_ready, index1, index2}, {1'b1, 1'b0, 32'd0});
`ifndef FC_LOADER_CHKSUM_EN
        check("done_latency", 64'(cyc - last_strobe_cyc), 64'd1);
`endif
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit stall);
    int guard = 0;
    if (stall && $urandom_range(0, 15) == 0) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && guard < 16) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 16) check("s_ready_timeout", {63'd0, s_ready}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int bound, input int d0);
    for (int i = 0; i < bound && done_cnt == d0; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {s_ready, index1, index2, din_we, din, w_we, wout, busy, done, err},
          {1'b1, 16'd0, 16'd0, 1'b0, 8'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    logic [7:0] x;
    logic [7:0] b;
    int d0, s0, c0;

    // Reset values
    #12;
    check_reset_vals("reset_state");
    check("reset_s_ready", {63'd0, s_ready}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset mid-stream after 100 input bytes
    send(8'hA1, 0);
    for (int k = 0; k < 100; k++) begin
      send(8'(k), 0);
      sb.push_back(pack(0, k, 0, k % 256));
    end
    s_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_vals("reset_mid_load");
    check("sb_after_reset", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Full input load, s_valid held high
    d0 = done_cnt; s0 = srdy_low; c0 = din_cnt; x = '0;
    send(8'hA1, 0);
    check("busy_after_cmd", {63'd0, busy}, 64'd1);
    for (int k = 0; k < N_IN; k++) begin
      b = 8'(k % 256);
      send(b, 0);
      sb.push_back(pack(0, k, 0, k % 256));
      x ^= b;
    end
`ifdef FC_LOADER_CHKSUM_EN
    send(x, 0);
`endif
    s_valid = 1'b0;
    wait_done(20, d0);
    check("in_strobes", 64'(din_cnt - c0), 64'(N_IN));
    check("in_ready_low", 64'(srdy_low - s0), 64'd1);
    check("in_idle_busy", {63'd0, busy}, 64'd0);

    // Weight load with random stalls
    d0 = done_cnt; s0 = srdy_low; c0 = w_cnt; x = '0;
    send(8'hA2, 0);
    for (int j = 0; j < N_IN * N_OUT; j++) begin
      send(8'hF3, 1);
      send(8'h5A, 1);
      sb.push_back(pack(1, j % N_IN, j / N_IN, 12'h35A));
      x ^= 8'hF3 ^ 8'h5A;
    end
`ifdef FC_LOADER_CHKSUM_EN
    send(x, 1);
`endif
    s_valid = 1'b0;
    wait_done(20, d0);
    check("w_strobes", 64'(w_cnt - c0), 64'(N_IN * N_OUT));
    check("w_ready_low", 64'(srdy_low - s0), 64'd1);

    // Illegal command, then recovery with a command-as-data payload
    d0 = done_cnt;
    send(8'h55, 0);
    s_valid = 1'b0;
    check("illegal_err", {62'd0, err, busy}, {62'd0, 1'b1, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    check("illegal_err_hold", {63'd0, err}, 64'd1);
    check("illegal_no_done", 64'(done_cnt - d0), 64'd0);
    send(8'hA1, 0);
    check("cmd_clears_err", {62'd0, err, busy}, {62'd0, 1'b0, 1'b1});
    c0 = din_cnt; x = '0;
    for (int k = 0; k < N_IN; k++) begin
      send(8'hA2, 0);
      sb.push_back(pack(0, k, 0, 8'hA2));
      x ^= 8'hA2;
    end
`ifdef FC_LOADER_CHKSUM_EN
    send(x, 0);
`endif
    s_valid = 1'b0;
    wait_done(20, d0);
    check("data_cmd_strobes", 64'(din_cnt - c0), 64'(N_IN));

`ifdef FC_LOADER_CHKSUM_EN
    // Wrong trailer: err set, no done, back to idle
    d0 = done_cnt; x = '0;
    send(8'hA1, 0);
    for (int k = 0; k < N_IN; k++) begin
      b = 8'($urandom);
      send(b, 0);
      sb.push_back(pack(0, k, 0, int'(b)));
      x ^= b;
    end
    send(x ^ 8'h01, 0);
    s_valid = 1'b0;
    check("chk_bad_err", {62'd0, err, busy}, {62'd0, 1'b1, 1'b0});
    repeat (5) @(posedge clk);
    #1;
    check("chk_bad_no_done", 64'(done_cnt - d0), 64'd0);
    check("chk_bad_idx", {32'd0, index1, index2}, 64'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_leftover", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fc_param_loader.md
# fc_param_loader

Write-side companion to the result-dump path of the fully-connected network. Accepts a host byte stream (valid/ready), decodes a one-byte command, and writes either the 784-entry 8-bit input vector or the 784×40 12-bit weight array into the network memories. Uses the same index1 (input position) / index2 (neuron) addressing and ordering that the verification dump reads back, so a load-then-dump round trip compares entry-for-entry.

## Interface
- N_IN, 784, input-vector length; index1 range 0..N_IN-1
- N_OUT, 40, neuron count; index2 range 0..N_OUT-1
- IDXW, 16, width of index1/index2
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- s_valid  in  1  host byte valid
- s_data  in  8  host byte
- s_ready  out  1  loader can accept byte this cycle
- index1  out  IDXW  write address, input position
- index2  out  IDXW  write address, neuron (0 during input-vector load)
- din_we  out  1  one-cycle input-vector write strobe
- din  out  8  input-vector write data
- w_we  out  1  one-cycle weight write strobe
- wout  out  12  weight write data
- busy  out  1  load in progress
- done  out  1  one-cycle pulse, load completed
- err  out  1  sticky error flag

## Operation
- Byte accepted when s_valid && s_ready; s_valid low stalls, no state change.
- States: IDLE, IN_LOAD, W_HI, W_LO, CHK (macro only), FIN.
- IDLE: 0xA1 -> IN_LOAD; 0xA2 -> W_HI; any other byte -> set err, stay IDLE. Accepting 0xA1/0xA2 clears err, zeroes index1/index2.
- IN_LOAD: each byte -> din = byte, din_we pulse at current (index1, index2=0), then index advance.
- W_HI: byte[3:0] latched as weight[11:8]; byte[7:4] ignored -> W_LO.
- W_LO: weight[7:0] = byte; wout = {hi, byte}, w_we pulse at current indices, then advance -> W_HI.
- Index advance: index1 == N_IN-1 -> index1 = 0, index2 + 1; else index1 + 1. Load ends after write at (N_IN-1, 0) for input vector, (N_IN-1, N_OUT-1) for weights -> FIN (or CHK).
- FIN: s_ready = 0 for one cycle, done = 1, index1/index2 = 0 -> IDLE.
- Command values inside a payload are data, not commands.
- Reset mid-load: immediate return to IDLE, all outputs reset values; partial data in memory is not scrubbed.

## Timing
- Reset values: s_ready 1, index1 0, index2 0, din_we 0, din 0, w_we 0, wout 0, busy 0, done 0, err 0.
- s_ready = 1 in every state except FIN.
- Write latency: din_we/w_we and data registered, asserted the cycle after the accepting edge; index1/index2 hold the write address during the strobe cycle and advance on the following edge.
- Max throughput: one input byte per cycle; one weight per two bytes.
- busy = 1 from the cycle after command accept through the FIN cycle.
- done: single cycle, one cycle after the final write strobe (or checksum byte).
- err asserts cycle after the bad byte; holds until next valid command.
- Input load: 785 bytes total; weight load: 1 + 2·N_IN·N_OUT = 62721 bytes.

## Configuration
- FC_LOADER_CHKSUM_EN defined: after the last payload byte, state CHK expects one byte = XOR of all payload bytes (command excluded). Match -> FIN, done pulse. Mismatch -> err = 1, no done pulse, -> IDLE with indices 0.
- Undefined: no CHK state, no trailer byte; done follows the final write directly; err only from illegal commands.

## Test plan
- Reset mid-stream: assert rst after 100 input bytes -> all outputs at reset values same cycle; next 0xA1 restarts at index1 0.
- Input load: 0xA1 then bytes k mod 256, k=0..783, s_valid held high -> 784 din_we pulses, din = k mod 256 at index1 k, index2 0; done one cycle after last pulse; s_ready 0 only that cycle.
- Weight load with stalls: 0xA2, pairs (0xF3,0x5A) repeated, s_valid toggled randomly -> wout = 0x35A every strobe; index1 wraps 783->0 with index2 +1; last strobe at (783,39); 31360 w_we pulses.
- Illegal command: byte 0x55 in IDLE -> err = 1, no strobes, busy 0; then 0xA1 -> err cleared next cycle.
- Command byte as data: 0xA1 followed by 784 bytes of 0xA2 -> 784 din_we with din 0xA2, no state re-entry.
- FC_LOADER_CHKSUM_EN: input load with correct XOR trailer -> done; with trailer XOR^0x01 -> err = 1, no done.
